// File: rtl/an_rx_cic.sv
// an_rx_cic: 3rd-order CIC decimator recovering 16-bit PCM from a 1-bit
// delta-sigma stream, with a valid/ready output register and sticky flags.
// Optional macro AN_RX_CIC_DIFF_CHK_EN compiles in the DS/XDS complement check.
// C_DECIM_RATIO must be one of 32, 64, 128 or 256.
module an_rx_cic #(
  parameter int C_DECIM_RATIO  = 64,
  parameter int C_SIM_NO_PRIME = 0
) (
  input  logic               CK_i,
  input  logic               RST_i,
  input  logic               DS_i,
  input  logic               XDS_i,
  input  logic               DS_EN_i,
  output logic signed [15:0] PCMs_o,
  output logic               PCM_VALID_o,
  input  logic               PCM_READY_i,
  output logic               OVR_o,
  input  logic               ERR_CLR_i,
  output logic               DIFF_ERR_o
);

  localparam int LOG2R = $clog2(C_DECIM_RATIO);
  localparam int W     = 3 * LOG2R + 2;
  localparam int SHIFT = 3 * LOG2R - 15;
  localparam logic [LOG2R-1:0]     CNT_LAST = LOG2R'(C_DECIM_RATIO - 1);
  localparam logic signed [W-1:0]  SAT_HI   = W'(32767);
  localparam logic signed [W-1:0]  SAT_LO   = W'(-32768);

  // filter state
  logic [LOG2R-1:0]    cnt_q, cnt_d;
  logic [W-1:0]        int1_q, int1_d, int2_q, int2_d, int3_q, int3_d;
  logic [W-1:0]        dly1_q, dly1_d, dly2_q, dly2_d, dly3_q, dly3_d;
  logic signed [W-1:0] y_q, y_d;
  logic signed [15:0]  sat_q, sat_d;
  // vld_pipe[0]: comb output registered, vld_pipe[1]: saturated sample ready
  logic [1:0]          vld_pipe_q, vld_pipe_d;
  logic [1:0]          prime_q, prime_d;
  // output register and flags
  logic signed [15:0]  pcm_q, pcm_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;
  logic                diff_q, diff_d;

  logic [W-1:0]        x;
  logic                dec;
  logic [W-1:0]        c1, c2, c3;
  logic signed [W-1:0] ys;
  logic                priming;
  logic                hshk;
  logic                diff_set;

  // integrators at input rate; combs run only on the decimation bit
  always_comb begin
    x      = DS_i ? W'(1) : '1;
    dec    = DS_EN_i && (cnt_q == CNT_LAST);
    cnt_d  = cnt_q;
    int1_d = int1_q;
    int2_d = int2_q;
    int3_d = int3_q;
    if (DS_EN_i) begin
      cnt_d  = cnt_q + 1'b1;
      int1_d = int1_q + x;
      int2_d = int2_q + int1_q;
      int3_d = int3_q + int2_q;
    end
    c1     = int3_d - dly1_q;
    c2     = c1 - dly2_q;
    c3     = c2 - dly3_q;
    dly1_d = dly1_q;
    dly2_d = dly2_q;
    dly3_d = dly3_q;
    y_d    = y_q;
    if (dec) begin
      dly1_d = int3_d;
      dly2_d = c1;
      dly3_d = c2;
      y_d    = c3;
    end
    vld_pipe_d = {vld_pipe_q[0], dec};
  end

  // scale the comb output to 16 bits and clamp full-scale to the PCM range
  always_comb begin
    ys    = y_q >>> SHIFT;
    sat_d = sat_q;
    if (vld_pipe_q[0]) begin
      if (ys > SAT_HI)      sat_d = 16'sh7fff;
      else if (ys < SAT_LO) sat_d = 16'sh8000;
      else                  sat_d = ys[15:0];
    end
  end

  // output register: drop priming samples, handshake, overwrite on overrun
  always_comb begin
    priming = (C_SIM_NO_PRIME == 0) && (prime_q != 2'd3);
    hshk    = valid_q && PCM_READY_i;
    prime_d = prime_q;
    pcm_d   = pcm_q;
    valid_d = valid_q && !hshk;
    ovr_d   = ovr_q && !ERR_CLR_i;
    if (vld_pipe_q[1]) begin
      if (priming) begin
        prime_d = prime_q + 2'd1;
      end else begin
        pcm_d   = sat_q;
        valid_d = 1'b1;
        if (valid_q && !PCM_READY_i) ovr_d = 1'b1;
      end
    end
  end

`ifdef AN_RX_CIC_DIFF_CHK_EN
  // complement check: a valid stream pair never has DS equal to XDS
  always_comb begin
    diff_set = DS_EN_i && (DS_i == XDS_i);
    diff_d   = diff_set || (diff_q && !ERR_CLR_i);
  end
`else
  logic unused_xds;
  assign unused_xds = XDS_i;
  // check compiled out: flag held low
  always_comb begin
    diff_set = 1'b0;
    diff_d   = 1'b0;
  end
`endif

  // state registers with synchronous reset
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      cnt_q      <= '0;
      int1_q     <= '0;
      int2_q     <= '0;
      int3_q     <= '0;
      dly1_q     <= '0;
      dly2_q     <= '0;
      dly3_q     <= '0;
      y_q        <= '0;
      sat_q      <= '0;
      vld_pipe_q <= '0;
      prime_q    <= '0;
      pcm_q      <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
      diff_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      int1_q     <= int1_d;
      int2_q     <= int2_d;
      int3_q     <= int3_d;
      dly1_q     <= dly1_d;
      dly2_q     <= dly2_d;
      dly3_q     <= dly3_d;
      y_q        <= y_d;
      sat_q      <= sat_d;
      vld_pipe_q <= vld_pipe_d;
      prime_q    <= prime_d;
      pcm_q      <= pcm_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
      diff_q     <= diff_d;
    end
  end

  assign PCMs_o      = pcm_q;
  assign PCM_VALID_o = valid_q;
  assign OVR_o       = ovr_q;
  assign DIFF_ERR_o  = diff_q;

endmodule

// File: tb/tb_an_rx_cic.sv
// tb_an_rx_cic: directed bench for an_rx_cic at R=64 (default build or with
// AN_RX_CIC_DIFF_CHK_EN defined). Tick index c counts edges after reset release.
module tb_an_rx_cic;
  logic clk = 1'b0;
  logic rst, ds, xds, ds_en, ready, err_clr;
  logic signed [15:0] pcm;
  logic valid, ovr, diff;
  int checks = 0;
  int failures = 0;

  an_rx_cic #(.C_DECIM_RATIO(64), .C_SIM_NO_PRIME(0)) dut (
    .CK_i(clk), .RST_i(rst), .DS_i(ds), .XDS_i(xds), .DS_EN_i(ds_en),
    .PCMs_o(pcm), .PCM_VALID_o(valid), .PCM_READY_i(ready), .OVR_o(ovr),
    .ERR_CLR_i(err_clr), .DIFF_ERR_o(diff));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ds_en = 1'b1; ready = 1'b1; err_clr = 1'b1; ds = 1'b1; xds = 1'b1;
    tick(); tick();
    rst = 1'b0; ds_en = 1'b0; ready = 1'b1; err_clr = 1'b0; xds = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pcm !== 16'sd0 || valid !== 1'b0 || ovr !== 1'b0 || diff !== 1'b0) begin
      failures++;
      $display("FAIL reset: pcm=%0d valid=%b ovr=%b diff=%b, want 0 0 0 0", pcm, valid, ovr, diff);
    end
  endtask

  // mode 0: DS=1, 1: DS=0, 2: alternating 1,0 per enabled bit
  task automatic run_stream(input string nm, input int mode, input int en_per,
                            input logic signed [15:0] expv, input int first,
                            input int per, input int nticks);
    int nbits;
    logic ev;
    do_reset();
    ready = 1'b1;
    nbits = 0;
    for (int c = 1; c <= nticks; c++) begin
      ds_en = ((c - 1) % en_per) == 0;
      case (mode)
        0: ds = 1'b1;
        1: ds = 1'b0;
        default: ds = (nbits % 2) == 0;
      endcase
      xds = ~ds;
      if (ds_en) nbits++;
      tick();
      ev = (c >= first) && (((c - first) % per) == 0);
      checks++;
      if (valid !== ev) begin
        failures++;
        $display("FAIL %s valid tick %0d: got %b want %b", nm, c, valid, ev);
      end
      if (ev) begin
        checks++;
        if (pcm !== expv) begin
          failures++;
          $display("FAIL %s pcm tick %0d: got %0d want %0d", nm, c, pcm, expv);
        end
      end
    end
    ds_en = 1'b0;
  endtask

  task automatic test_overrun();
    do_reset();
    ds = 1'b1; xds = 1'b0; ds_en = 1'b1; ready = 1'b0;
    for (int c = 1; c <= 452; c++) begin
      err_clr = (c == 386) || (c == 387);
      ready   = (c >= 450);
      tick();
      if (c == 258 || c == 300) begin
        checks++;
        if (valid !== 1'b1 || pcm !== 16'sd32767 || ovr !== 1'b0) begin
          failures++;
          $display("FAIL ovr_hold tick %0d: v=%b pcm=%0d ovr=%b want 1 32767 0", c, valid, pcm, ovr);
        end
      end
      if (c == 322 || c == 386) begin
        checks++;
        if (valid !== 1'b1 || ovr !== 1'b1) begin
          failures++;
          $display("FAIL ovr_set tick %0d: v=%b ovr=%b want 1 1", c, valid, ovr);
        end
      end
      if (c == 387) begin
        checks++;
        if (ovr !== 1'b0 || valid !== 1'b1) begin
          failures++;
          $display("FAIL ovr_clr: ovr=%b v=%b want 0 1", ovr, valid);
        end
      end
      if (c == 450) begin
        checks++;
        if (valid !== 1'b1 || ovr !== 1'b0 || pcm !== 16'sd32767) begin
          failures++;
          $display("FAIL hshk_same_edge: v=%b ovr=%b pcm=%0d want 1 0 32767", valid, ovr, pcm);
        end
      end
      if (c == 451) begin
        checks++;
        if (valid !== 1'b0) begin
          failures++;
          $display("FAIL hshk_drop: v=%b want 0", valid);
        end
      end
    end
    err_clr = 1'b0; ready = 1'b1; ds_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    ds = 1'b1; xds = 1'b0; ds_en = 1'b1; ready = 1'b0;
    for (int c = 1; c <= 286; c++) tick();
    checks++;
    if (valid !== 1'b1 || pcm !== 16'sd32767) begin
      failures++;
      $display("FAIL pre_rst: v=%b pcm=%0d want 1 32767", valid, pcm);
    end
    rst = 1'b1; ready = 1'b1; err_clr = 1'b1;
    tick();
    checks++;
    if (pcm !== 16'sd0 || valid !== 1'b0 || ovr !== 1'b0 || diff !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst: pcm=%0d v=%b ovr=%b diff=%b want 0 0 0 0", pcm, valid, ovr, diff);
    end
    rst = 1'b0; err_clr = 1'b0; ready = 1'b1;
    for (int c = 1; c <= 258; c++) begin
      tick();
      if (c == 257) begin
        checks++;
        if (valid !== 1'b0) begin
          failures++;
          $display("FAIL post_rst_prime: v=%b want 0", valid);
        end
      end
    end
    checks++;
    if (valid !== 1'b1 || pcm !== 16'sd32767) begin
      failures++;
      $display("FAIL post_rst_first: v=%b pcm=%0d want 1 32767", valid, pcm);
    end
    ds_en = 1'b0;
  endtask

  task automatic test_diff();
    logic expd;
    do_reset();
    ds = 1'b1; xds = 1'b0; ds_en = 1'b1;
    tick(); tick();
    checks++;
    if (diff !== 1'b0) begin
      failures++;
      $display("FAIL diff_idle: got %b want 0", diff);
    end
    xds = 1'b1;
    tick();
    xds = 1'b0;
    tick(); tick();
`ifdef AN_RX_CIC_DIFF_CHK_EN
    expd = 1'b1;
`else
    expd = 1'b0;
`endif
    checks++;
    if (diff !== expd) begin
      failures++;
      $display("FAIL diff_sticky: got %b want %b", diff, expd);
    end
    err_clr = 1'b1; ds_en = 1'b0; xds = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    checks++;
    if (diff !== 1'b0) begin
      failures++;
      $display("FAIL diff_clr: got %b want 0", diff);
    end
    xds = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ds = 1'b0; xds = 1'b1; ds_en = 1'b0; ready = 1'b1; err_clr = 1'b0;
    test_reset();
    run_stream("dc_pos", 0, 1, 16'sd32767, 258, 64, 400);
    run_stream("dc_neg", 1, 1, -16'sd32768, 258, 64, 400);
    run_stream("alt", 2, 1, 16'sd0, 258, 64, 400);
    run_stream("en_3rd", 0, 3, 16'sd32767, 768, 192, 1000);
    test_overrun();
    test_reset_mid();
    test_diff();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
